// File: rtl/data_memory.sv
// Word-addressed data memory with combinational read, single-edge write and
// asynchronous clear. Access status reports reset, range and alignment errors.
module data_memory #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enabled,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic [1:0]  status
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Region size in bytes, widened so BASE_ADDR + size cannot wrap at 2^32.
  localparam logic [33:0] SpanBytes = 34'(DEPTH_WORDS) * 34'd4;

  localparam logic [1:0] StOk         = 2'b00;
  localparam logic [1:0] StMisaligned = 2'b01;
  localparam logic [1:0] StRange      = 2'b10;
  localparam logic [1:0] StReset      = 2'b11;

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [33:0]     offset;
  logic            in_range;
  logic            aligned;
  logic [IdxW-1:0] idx;

  always_comb begin
    offset   = {2'b00, addr} - {2'b00, BASE_ADDR};
    in_range = (addr >= BASE_ADDR) && (offset < SpanBytes);
    aligned  = (addr[1:0] == 2'b00);
    idx      = offset[IdxW+1:2];
  end

  always_comb begin
    status = StOk;
    if (!reset) begin
      status = StReset;
    end else if (!in_range) begin
      status = StRange;
    end else if (!aligned) begin
      status = StMisaligned;
    end
  end

  always_comb begin
    r_data = 32'h0;
    if (status == StOk) begin
      r_data = mem_q[idx];
    end
  end

  // Reset takes priority, so an edge coinciding with reset assertion never writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (write_enabled && (status == StOk)) begin
      mem_q[idx] <= w_data;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus queues expected read data/status,
// a monitor pops and compares each time a sample is presented.
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic        write_enabled;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic [1:0]  status;

  typedef struct {
    string       name;
    logic [31:0] r;
    logic [1:0]  s;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   total = 0;
  int   bad   = 0;

  data_memory #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write_enabled(write_enabled),
    .addr         (addr),
    .w_data       (w_data),
    .r_data       (r_data),
    .status       (status)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor: pops one expectation per presented sample.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sample_without_expectation: r_data=%h status=%b", r_data, status);
      end else begin
        e = sb.pop_front();
        total++;
        if (r_data !== e.r || status !== e.s) begin
          bad++;
          $display("FAIL %s: got r_data=%h status=%b, want r_data=%h status=%b",
                   e.name, r_data, status, e.r, e.s);
        end
      end
    end
  end

  task automatic expect_now(input string name, input logic [31:0] r, input logic [1:0] s);
    exp_t e;
    #1;
    e.name = name;
    e.r    = r;
    e.s    = s;
    sb.push_back(e);
    -> sample_ev;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    write_enabled = we;
    addr          = a;
    w_data        = d;
  endtask

  task automatic read_at(input string name, input logic [31:0] a, input logic [31:0] r,
                         input logic [1:0] s);
    @(negedge clk);
    drive(1'b0, a, 32'h0);
    expect_now(name, r, s);
  endtask

  task automatic write_at(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(1'b1, a, d);
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    expect_now("reset_status", 32'h0, 2'b11);
    // A write strobe held through a reset edge must not land.
    drive(1'b1, 32'h10, 32'h5555_5555);
    @(posedge clk);
    expect_now("reset_write_blocked", 32'h0, 2'b11);

    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    expect_now("post_reset_0x0", 32'h0, 2'b00);
    drive(1'b0, 32'h4, 32'h0);
    expect_now("post_reset_0x4", 32'h0, 2'b00);
    drive(1'b0, 32'hFFC, 32'h0);
    expect_now("post_reset_0xffc", 32'h0, 2'b00);
    // First edge after release accepts a write; old value seen before it.
    drive(1'b1, 32'h10, 32'hDEAD_BEEF);
    expect_now("first_write_before_edge", 32'h0, 2'b00);
    @(posedge clk);
    expect_now("first_write_after_edge", 32'hDEAD_BEEF, 2'b00);

    read_at("read_0x10", 32'h10, 32'hDEAD_BEEF, 2'b00);
    read_at("read_0x14", 32'h14, 32'h0, 2'b00);

    @(negedge clk);
    drive(1'b1, 32'h12, 32'hFFFF_FFFF);
    expect_now("misaligned_status", 32'h0, 2'b01);
    @(negedge clk);
    drive(1'b1, 32'h1000, 32'hFFFF_FFFF);
    expect_now("out_of_range_status", 32'h0, 2'b10);
    @(negedge clk);
    drive(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    expect_now("top_of_space_status", 32'h0, 2'b10);
    @(posedge clk);
    read_at("0x10_unchanged", 32'h10, 32'hDEAD_BEEF, 2'b00);
    read_at("0x0_unchanged", 32'h0, 32'h0, 2'b00);

    write_at(32'h20, 32'h1);
    @(negedge clk);
    drive(1'b1, 32'h20, 32'h2);
    expect_now("raw_before_edge", 32'h1, 2'b00);
    @(posedge clk);
    expect_now("raw_after_edge", 32'h2, 2'b00);

    write_at(32'h0, 32'h1);
    write_at(32'h4, 32'h2);
    write_at(32'h8, 32'h3);
    write_at(32'hC, 32'h4);
    read_at("b2b_0x0", 32'h0, 32'h1, 2'b00);
    read_at("b2b_0x4", 32'h4, 32'h2, 2'b00);
    read_at("b2b_0x8", 32'h8, 32'h3, 2'b00);
    read_at("b2b_0xc", 32'hC, 32'h4, 2'b00);
    read_at("b2b_0xffc", 32'hFFC, 32'h0, 2'b00);

    write_at(32'h8, 32'hA5A5_A5A5);
    read_at("a5_written", 32'h8, 32'hA5A5_A5A5, 2'b00);
    @(negedge clk);
    drive(1'b1, 32'h8, 32'h1234_5678);
    #3 reset = 1'b0;
    expect_now("mid_cycle_reset", 32'h0, 2'b11);
    @(posedge clk);
    expect_now("reset_held_edge", 32'h0, 2'b11);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 32'h8, 32'h0);
    expect_now("cleared_0x8", 32'h0, 2'b00);
    read_at("cleared_0x10", 32'h10, 32'h0, 2'b00);
    read_at("cleared_0x20", 32'h20, 32'h0, 2'b00);

    #2;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
